if_fetch_queue: RTL and testbench

Parametrised instruction-fetch front end that generates the PC, issues one-outstanding fetch requests to the instruction cache controller and buffers returned instructions in a DEPTH-entry FIFO ahead of the IF/ID boundary. This decouples I-cache miss latency from decode stalls and adds kill-on-redirect of in-flight fetches. It sits between the icache controller and the ID stage, in place of a single IF register.

---
 rtl/if_fetch_queue.sv | 169 ++++++++++++++++
 tb/tb_if_fetch_queue.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: PC generation, one-outstanding I-cache fetch, DEPTH-entry queue to ID.
// Optional perf counters enabled by defining IF_FETCH_PERF_EN.
module if_fetch_queue #(
  parameter int ADDR_W = 32,
  parameter int INSN_W = 32,
  parameter int DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              ic_req,
  output logic [ADDR_W-1:0] ic_addr,
  input  logic              ic_ack,
  input  logic [INSN_W-1:0] ic_insn,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_addr,
  output logic              if_en,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INSN_W-1:0] if_insn,
  output logic              fetch_busy,
  output logic [1:0]        dbg_state
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]       perf_miss_cyc,
  output logic [31:0]       perf_redirect,
  output logic [31:0]       perf_full_cyc
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_n, addr_q;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_n;
  logic [CNT_W-1:0]  count, count_n;
  logic [ADDR_W-1:0] q_pc   [DEPTH];
  logic [INSN_W-1:0] q_insn [DEPTH];
  logic [ADDR_W-1:0] head_pc, head_pc_n;
  logic [INSN_W-1:0] head_insn, head_insn_n;
  logic              redirect, push, pop;
  logic [ADDR_W-1:0] target;

  // Handshakes: ic_req is a level held with a stable ic_addr until the one-cycle ic_ack completes it;
  // the queue head is consumed on any cycle with if_en=1 and stall=0, unless a redirect clears the queue.
  assign redirect = flush | br_taken;
  assign target   = flush ? new_pc : br_addr;
  assign push     = (state == S_FETCH) && ic_ack && !redirect;
  assign pop      = (count != '0) && !stall && !redirect;

  always_comb begin
    rd_ptr_n = rd_ptr;
    count_n  = count;
    if (redirect) begin
      count_n = '0;
    end else begin
      if (pop) rd_ptr_n = rd_ptr + PTR_W'(1);
      count_n = count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    case (state)
      S_IDLE: begin
        if (redirect) fetch_pc_n = target;
        else if (count < FULL_CNT) state_n = S_FETCH;
      end
      S_FETCH: begin
        if (redirect) begin
          fetch_pc_n = target;
          state_n    = ic_ack ? S_IDLE : S_DROP;
        end else if (ic_ack) begin
          fetch_pc_n = fetch_pc + ADDR_W'(4);
          state_n    = (count_n < FULL_CNT) ? S_FETCH : S_IDLE;
        end
      end
      S_DROP: begin
        if (redirect) fetch_pc_n = target;
        if (ic_ack) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Head is registered so if_pc/if_insn hold their last value once the queue empties.
  always_comb begin
    head_pc_n   = head_pc;
    head_insn_n = head_insn;
    if (!redirect && count_n != '0) begin
      if (count == '0 || (count == CNT_W'(1) && pop)) begin
        head_pc_n   = fetch_pc;
        head_insn_n = ic_insn;
      end else begin
        head_pc_n   = q_pc[rd_ptr_n];
        head_insn_n = q_insn[rd_ptr_n];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      fetch_pc  <= RESET_PC;
      addr_q    <= RESET_PC;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      head_pc   <= '0;
      head_insn <= '0;
    end else begin
      state     <= state_n;
      fetch_pc  <= fetch_pc_n;
      // An abandoned request keeps its address on the bus until the cache acks it.
      addr_q    <= (state_n == S_DROP) ? addr_q : fetch_pc_n;
      count     <= count_n;
      head_pc   <= head_pc_n;
      head_insn <= head_insn_n;
      if (redirect) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        rd_ptr <= rd_ptr_n;
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]   <= fetch_pc;
      q_insn[wr_ptr] <= ic_insn;
    end
  end

  assign ic_req     = (state != S_IDLE);
  assign fetch_busy = (state != S_IDLE);
  assign ic_addr    = addr_q;
  assign if_en      = (count != '0);
  assign if_pc      = head_pc;
  assign if_insn    = head_insn;
  assign dbg_state  = state;

`ifdef IF_FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_miss_cyc <= '0;
      perf_redirect <= '0;
      perf_full_cyc <= '0;
    end else begin
      if (state != S_IDLE && !ic_ack) perf_miss_cyc <= perf_miss_cyc + 32'd1;
      if (redirect) perf_redirect <= perf_redirect + 32'd1;
      if (count == FULL_CNT) perf_full_cyc <= perf_full_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: directed fetch/redirect/reset scenarios with an expected-entry queue.
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_ack = 1'b0;
  logic [31:0] ic_insn = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] new_pc = '0;
  logic        br_taken = 1'b0;
  logic [31:0] br_addr = '0;
  logic        if_en;
  logic [31:0] if_pc;
  logic [31:0] if_insn;
  logic        fetch_busy;
  logic [1:0]  dbg_state;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_miss_cyc, perf_redirect, perf_full_cyc;
`endif

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  if_fetch_queue dut (
    .clk(clk), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack), .ic_insn(ic_insn),
    .stall(stall), .flush(flush), .new_pc(new_pc), .br_taken(br_taken), .br_addr(br_addr),
    .if_en(if_en), .if_pc(if_pc), .if_insn(if_insn), .fetch_busy(fetch_busy),
    .dbg_state(dbg_state)
`ifdef IF_FETCH_PERF_EN
    , .perf_miss_cyc(perf_miss_cyc), .perf_redirect(perf_redirect), .perf_full_cyc(perf_full_cyc)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk_insn(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    ic_ack = 1'b0; stall = 1'b0; flush = 1'b0; br_taken = 1'b0;
    exp_q.delete();
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (ic_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (ic_req !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL req_timeout actual=0 expected=1");
    end
  endtask

  task automatic do_ack(input logic [31:0] a, input bit keep);
    wait_req();
    chk("ic_addr", {32'h0, ic_addr}, {32'h0, a});
    ic_ack  = 1'b1;
    ic_insn = mk_insn(a);
    if (keep) exp_q.push_back({a, mk_insn(a)});
    tick();
    ic_ack = 1'b0;
  endtask

  task automatic drain();
    stall = 1'b0;
    repeat (6) tick();
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    chk("drain_if_en", {63'h0, if_en}, 64'd0);
  endtask

  // scoreboard monitor: a head is consumed at the next edge when if_en & !stall & no redirect
  always @(negedge clk) begin
    if (reset) begin
      if (flush || br_taken) begin
        exp_q.delete();
      end else if (if_en && !stall) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_head actual=%0h expected=none", {if_pc, if_insn});
        end else begin
          chk("head", {if_pc, if_insn}, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    // reset values and release
    reset = 1'b0;
    tick();
    tick();
    chk("rst_ic_req", {63'h0, ic_req}, 64'd0);
    chk("rst_ic_addr", {32'h0, ic_addr}, 64'd0);
    chk("rst_if_en", {63'h0, if_en}, 64'd0);
    chk("rst_if_pc", {32'h0, if_pc}, 64'd0);
    chk("rst_if_insn", {32'h0, if_insn}, 64'd0);
    chk("rst_busy", {63'h0, fetch_busy}, 64'd0);
    reset = 1'b1;
    tick();
    chk("rel_ic_req", {63'h0, ic_req}, 64'd1);
    chk("rel_busy", {63'h0, fetch_busy}, 64'd1);

    // streaming hits, one instruction per cycle
    do_ack(32'h0, 1'b1);
    chk("stream_if_en", {63'h0, if_en}, 64'd1);
    chk("stream_if_pc", {32'h0, if_pc}, 64'd0);
    for (int i = 1; i < 8; i++) do_ack(32'(i * 4), 1'b1);
    drain();

    // fill under stall, then resume
    do_reset();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) do_ack(32'(i * 4), 1'b1);
    chk("full_ic_req", {63'h0, ic_req}, 64'd0);
    chk("full_busy", {63'h0, fetch_busy}, 64'd0);
    chk("full_if_en", {63'h0, if_en}, 64'd1);
    chk("full_if_pc", {32'h0, if_pc}, 64'd0);
    chk("full_if_insn", {32'h0, if_insn}, {32'h0, mk_insn(32'h0)});
    repeat (3) tick();
    chk("full_hold_req", {63'h0, ic_req}, 64'd0);
    stall = 1'b0;
    do_ack(32'h10, 1'b1);
    do_ack(32'h14, 1'b1);
    drain();

    // branch while a slow fetch is outstanding
    do_reset();
    do_ack(32'h0, 1'b1);
    do_ack(32'h4, 1'b1);
    tick();
    br_taken = 1'b1;
    br_addr  = 32'h100;
    tick();
    br_taken = 1'b0;
    chk("drop_ic_req", {63'h0, ic_req}, 64'd1);
    chk("drop_busy", {63'h0, fetch_busy}, 64'd1);
    chk("drop_ic_addr", {32'h0, ic_addr}, 64'h8);
    chk("drop_if_en", {63'h0, if_en}, 64'd0);
    repeat (2) tick();
    do_ack(32'h8, 1'b0);
    chk("post_drop_req", {63'h0, ic_req}, 64'd0);
    chk("post_drop_addr", {32'h0, ic_addr}, 64'h100);
    do_ack(32'h100, 1'b1);
    do_ack(32'h104, 1'b1);
    drain();

    // flush and branch together with an ack, queue non-empty under stall
    do_reset();
    stall = 1'b1;
    do_ack(32'h0, 1'b1);
    do_ack(32'h4, 1'b1);
    wait_req();
    chk("fl_ic_addr", {32'h0, ic_addr}, 64'h8);
    ic_ack = 1'b1; ic_insn = mk_insn(32'h8);
    flush = 1'b1; new_pc = 32'h200;
    br_taken = 1'b1; br_addr = 32'h300;
    tick();
    ic_ack = 1'b0; flush = 1'b0; br_taken = 1'b0;
    chk("fl_if_en", {63'h0, if_en}, 64'd0);
    chk("fl_ic_req", {63'h0, ic_req}, 64'd0);
    chk("fl_busy", {63'h0, fetch_busy}, 64'd0);
    chk("fl_ic_addr_new", {32'h0, ic_addr}, 64'h200);
    chk("fl_if_pc_hold", {32'h0, if_pc}, 64'h0);
    chk("fl_if_insn_hold", {32'h0, if_insn}, {32'h0, mk_insn(32'h0)});
    stall = 1'b0;
    do_ack(32'h200, 1'b1);
    do_ack(32'h204, 1'b1);
    drain();

    // address wrap
    do_reset();
    flush  = 1'b1;
    new_pc = 32'hFFFF_FFF8;
    tick();
    flush = 1'b0;
    chk("wrap_idle_req", {63'h0, ic_req}, 64'd0);
    chk("wrap_idle_addr", {32'h0, ic_addr}, 64'hFFFF_FFF8);
    do_ack(32'hFFFF_FFF8, 1'b1);
    do_ack(32'hFFFF_FFFC, 1'b1);
    do_ack(32'h0, 1'b1);
    drain();

    // reset during a fetch with three entries queued, then a stray ack
    do_reset();
    stall = 1'b1;
    do_ack(32'h0, 1'b1);
    do_ack(32'h4, 1'b1);
    do_ack(32'h8, 1'b1);
    chk("mid_if_en", {63'h0, if_en}, 64'd1);
    chk("mid_ic_req", {63'h0, ic_req}, 64'd1);
    reset = 1'b0;
    #1;
    exp_q.delete();
    chk("arst_if_en", {63'h0, if_en}, 64'd0);
    chk("arst_ic_req", {63'h0, ic_req}, 64'd0);
    chk("arst_ic_addr", {32'h0, ic_addr}, 64'd0);
    chk("arst_busy", {63'h0, fetch_busy}, 64'd0);
    chk("arst_if_pc", {32'h0, if_pc}, 64'd0);
    tick();
    reset   = 1'b1;
    ic_ack  = 1'b1;
    ic_insn = 32'hDEAD_BEEF;
    tick();
    ic_ack = 1'b0;
    chk("stray_if_en", {63'h0, if_en}, 64'd0);
    chk("stray_ic_req", {63'h0, ic_req}, 64'd1);
    chk("stray_ic_addr", {32'h0, ic_addr}, 64'd0);
    stall = 1'b0;
    do_ack(32'h0, 1'b1);
    drain();

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
